store_unit: RTL and testbench

Multicycle store engine between the datapath and the shared data memory. It is the write-side counterpart of the write-back selection path. It takes a store request (`sw`/`sh`/`sb`) with address and register-B data. It issues the memory transactions needed, performing read-modify-write for sub-word stores, and signals completion to the control unit. The control unit holds its store state until `done`.

---
 rtl/store_pkg.sv | 22 ++
 rtl/store_merge.sv | 22 ++
 rtl/store_unit.sv | 145 ++++++++++++++
 tb/tb_store_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and lane widths for the store engine
package store_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_SW   = 2'b00,
        ST_SH   = 2'b01,
        ST_SB   = 2'b10,
        ST_RSVD = 2'b11
    } store_type_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } store_state_t;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - combinational lane merge of new store data into an old memory word
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  store_type_t type_i,
    input  logic [1:0]  byte_off_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        case (type_i)
            ST_SW: merged_o = new_data_i;
            ST_SH: merged_o[{byte_off_i[1], 4'b0000} +: HALF_W] = new_data_i[HALF_W-1:0];
            ST_SB: merged_o[{byte_off_i, 3'b000} +: BYTE_W] = new_data_i[BYTE_W-1:0];
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - multicycle store engine with read-modify-write for sub-word stores
// Optional alignment trap enabled by defining STORE_UNIT_ALIGN_CHECK_EN.
module store_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    store_state_t state_q, state_d;
    store_type_t  type_q, type_d;
    logic [31:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;
    logic         rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, mis_q, mis_d;

    store_type_t  in_type;
    store_type_t  cur_type;
    logic [31:0]  cur_addr, cur_wdata, merged_word;
    logic         misaligned;

    assign in_type = store_type_t'(store_type);

    // In IDLE the request is still on the inputs; afterwards only captured copies are used.
    assign cur_type  = (state_q == S_IDLE) ? in_type : type_q;
    assign cur_addr  = (state_q == S_IDLE) ? addr    : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? wdata   : wdata_q;

`ifdef STORE_UNIT_ALIGN_CHECK_EN
    assign misaligned = ((in_type == ST_SW) && (addr[1:0] != 2'b00)) ||
                        ((in_type == ST_SH) && addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    store_merge u_merge (
        .old_word_i (mem_dout),
        .new_data_i (cur_wdata),
        .type_i     (cur_type),
        .byte_off_i (cur_addr[1:0]),
        .merged_o   (merged_word)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        mem_din_d = mem_din_q;
        mis_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    type_d  = in_type;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (misaligned) begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                    end else begin
                        case (in_type)
                            ST_SW:        state_d = S_WRITE;
                            ST_SH, ST_SB: state_d = S_READ;
                            default:      state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_WRITE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The merge register loads on the transition into WRITE (last WAIT cycle for RMW).
        if ((state_d == S_WRITE) && (state_q != S_WRITE)) mem_din_d = merged_word;
        rd_d       = (state_d == S_READ);
        wr_d       = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        mem_addr_d = busy_d ? {cur_addr[31:2], 2'b00} : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            type_q     <= ST_SW;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = rd_q;
    assign mem_wr   = wr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit at MEM_LAT 1 and 3
module tb_store_unit;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  st_type;
    logic [31:0] st_addr, st_wdata;
    logic [1:0]  start_s, rd_s, wr_s, busy_s, done_s, mis_s;
    logic [31:0] maddr_s [2];
    logic [31:0] mdin_s  [2];
    logic [31:0] mdout_s [2];
    logic [31:0] mem [16];

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [2:0] pipe = '0;
        always @(posedge clk) pipe <= {pipe[1:0], rd_s[g]};
        assign mdout_s[g] = pipe[LAT-1] ? mem[maddr_s[g][5:2]] : 32'hBAD0_BAD0;

        store_unit #(.MEM_LAT(LAT)) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .start      (start_s[g]),
            .store_type (st_type),
            .addr       (st_addr),
            .wdata      (st_wdata),
            .mem_addr   (maddr_s[g]),
            .mem_rd     (rd_s[g]),
            .mem_wr     (wr_s[g]),
            .mem_din    (mdin_s[g]),
            .mem_dout   (mdout_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .misalign   (mis_s[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] old, input logic [31:0] w,
                                          input logic [1:0] t, input logic [1:0] off);
        logic [31:0] mask;
        int          sh;
        if (t == 2'b10) begin
            sh   = 8 * off;
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = 16 * off[1];
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((w << sh) & mask);
    endfunction

    // Called at a negedge; the request is sampled at the next posedge (edge 0).
    task automatic run_store(input int inst, input logic [1:0] t, input logic [31:0] a,
                             input logic [31:0] w, input int exp_rd, input int exp_wr,
                             input int exp_done, input logic exp_mis, input logic [31:0] exp_din,
                             input logic poke);
        int   rd_c = 0, wr_c = 0, done_c = 0;
        logic mis_seen = 1'b0, overlap = 1'b0, busy_bad = 1'b0;
        wr_t  e;
        @(negedge clk);
        st_type = t; st_addr = a; st_wdata = w; start_s[inst] = 1'b1;
        if (exp_wr > 0) sb_q.push_back('{inst, {a[31:2], 2'b00}, exp_din});
        for (int cyc = 1; cyc <= 20 && done_c == 0; cyc++) begin
            @(negedge clk);
            start_s[inst] = 1'b0;
            if (rd_s[inst] && rd_c == 0) rd_c = cyc;
            if (rd_s[inst] && wr_s[inst]) overlap = 1'b1;
            if (!busy_s[inst]) busy_bad = 1'b1;
            if (wr_s[inst]) begin
                if (wr_c == 0) wr_c = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_wr", 32'(cyc), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("wr_inst", 32'(inst), 32'(e.inst));
                    check_eq("wr_addr", maddr_s[inst], e.addr);
                    check_eq("wr_data", mdin_s[inst], e.din);
                    mem[maddr_s[inst][5:2]] = mdin_s[inst];
                end
            end
            if (done_s[inst]) begin
                done_c   = cyc;
                mis_seen = mis_s[inst];
            end
            if (poke && cyc == 2) begin
                start_s[inst] = 1'b1;
                st_addr       = 32'h0000_0F00;
            end
        end
        check_eq("rd_cycle", 32'(rd_c), 32'(exp_rd));
        check_eq("wr_cycle", 32'(wr_c), 32'(exp_wr));
        check_eq("done_cycle", 32'(done_c), 32'(exp_done));
        check_eq("misalign", 32'(mis_seen), 32'(exp_mis));
        check_eq("busy_window", 32'(busy_bad), 32'h0);
        check_eq("rd_wr_overlap", 32'(overlap), 32'h0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] a, w, exp;
        logic [1:0]  t;
        int          inst;
        logic        bad;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h1122_3344;
        mem[8] = 32'h1234_5678;
        mem[9] = 32'hA5A5_A5A5;
        rst_n = 1'b0; start_s = '0; st_type = '0; st_addr = '0; st_wdata = '0;

        #12;
        check_eq("rst_strobes", {22'h0, rd_s, wr_s, busy_s, done_s, mis_s}, 32'h0);
        check_eq("rst_addr0", maddr_s[0], 32'h0);
        check_eq("rst_addr1", maddr_s[1], 32'h0);
        check_eq("rst_din0", mdin_s[0], 32'h0);
        check_eq("rst_din1", mdin_s[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_store(0, 2'b10, 32'h13, 32'h0000_00AB, 1, 3, 4, 1'b0, 32'hAB22_3344, 1'b0);
        run_store(0, 2'b00, 32'h10, 32'hDEAD_BEEF, 0, 1, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
        run_store(1, 2'b01, 32'h22, 32'hFFFF_CAFE, 1, 5, 6, 1'b0, 32'hCAFE_5678, 1'b0);
        run_store(1, 2'b01, 32'h24, 32'h0000_1234, 1, 5, 6, 1'b0, 32'hA5A5_1234, 1'b1);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
        run_store(0, 2'b00, 32'h06, 32'h0102_0304, 0, 0, 1, 1'b1, 32'h0, 1'b0);
        run_store(0, 2'b01, 32'h21, 32'h0000_7777, 0, 0, 1, 1'b1, 32'h0, 1'b0);
`else
        run_store(0, 2'b00, 32'h06, 32'h0102_0304, 0, 1, 2, 1'b0, 32'h0102_0304, 1'b0);
        run_store(0, 2'b01, 32'h21, 32'h0000_7777, 1, 3, 4, 1'b0,
                  model(mem[8], 32'h0000_7777, 2'b01, 2'b01), 1'b0);
`endif
        run_store(0, 2'b11, 32'h30, 32'h1111_1111, 0, 0, 1, 1'b0, 32'h0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            inst = k % 2;
            t    = (k < 4) ? 2'b10 : 2'b01;
            a    = 32'($urandom_range(0, 63));
            if (t == 2'b01) a[0] = 1'b0;
            w    = $urandom;
            exp  = model(mem[a[5:2]], w, t, a[1:0]);
            run_store(inst, t, a, w, 1, (inst == 0) ? 3 : 5, (inst == 0) ? 4 : 6, 1'b0, exp, 1'b0);
        end

        @(negedge clk);
        st_type = 2'b00; st_addr = 32'h30; st_wdata = 32'h5555_AAAA; start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        check_eq("rst_pre_wr", 32'(wr_s[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_wr", 32'(wr_s[0]), 32'h0);
        check_eq("rst_async_busy", 32'(busy_s[0]), 32'h0);
        check_eq("rst_async_addr", maddr_s[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_s[0] || wr_s[0] || busy_s[0]) bad = 1'b1;
        end
        check_eq("rst_no_resume", 32'(bad), 32'h0);
        check_eq("sb_final", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
